// File: rtl/value_predict_unit_pkg.sv
// rtl/value_predict_unit_pkg.sv - shared types and widths for the value predictor
package value_predict_unit_pkg;

    localparam int VP_DATA_WIDTH = 32;
    localparam int VP_ADDR_WIDTH = 32;
    localparam int VP_CONF_BITS  = 2;

    typedef enum logic [1:0] {
        VP_IDLE,
        VP_SPEC,
        VP_RECOVER
    } vp_state_t;

    // The tag field holds the PC shifted right past the index bits, so its
    // width does not depend on the table size.
    typedef struct packed {
        logic                     valid;
        logic [VP_ADDR_WIDTH-1:0] tag;
        logic [VP_DATA_WIDTH-1:0] value;
        logic [VP_CONF_BITS-1:0]  conf;
    } vp_entry_t;

    typedef struct packed {
        logic [VP_ADDR_WIDTH-1:0] pc;
        logic [VP_DATA_WIDTH-1:0] value;
        logic                     confident;
    } vp_queue_t;

endpackage

// File: rtl/value_predict_unit_if.sv
// rtl/value_predict_unit_if.sv - request/resolve/recovery bus of the value predictor
// master: hazard controller side (drives req_*, res_*, recovery_done)
// slave : value_predict_unit (drives req_ready, pred_*, take_snapshot, recover*, spec_active, counters)
interface value_predict_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic                  req_ready;
    logic                  pred_valid;
    logic [DATA_WIDTH-1:0] pred_value;
    logic                  pred_confident;
    logic                  res_valid;
    logic [DATA_WIDTH-1:0] res_data;
    logic                  take_snapshot;
    logic                  recover;
    logic [ADDR_WIDTH-1:0] recover_pc;
    logic                  recovery_done;
    logic                  spec_active;
    logic [31:0]           hit_count;
    logic [31:0]           miss_count;

    modport master (
        output req_valid, req_pc, res_valid, res_data, recovery_done,
        input  req_ready, pred_valid, pred_value, pred_confident, take_snapshot,
               recover, recover_pc, spec_active, hit_count, miss_count
    );

    modport slave (
        input  req_valid, req_pc, res_valid, res_data, recovery_done,
        output req_ready, pred_valid, pred_value, pred_confident, take_snapshot,
               recover, recover_pc, spec_active, hit_count, miss_count
    );
endinterface

// File: rtl/value_predict_unit_outstanding_queue.sv
// rtl/value_predict_unit_outstanding_queue.sv - in-order FIFO of outstanding predictions
// Ports: push/push_data enqueue, pop dequeues head, flush empties the FIFO,
// full/empty status, head = oldest entry, conf_count = confident entries held.
module vp_outstanding_queue
    import value_predict_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  vp_queue_t                push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output vp_queue_t                head,
    output logic [$clog2(DEPTH):0]   conf_count
);
    localparam int PW = $clog2(DEPTH);

    vp_queue_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            conf_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            conf_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count      <= count + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
            conf_count <= conf_count + (PW+1)'(push_ok & push_data.confident)
                                     - (PW+1)'(pop_ok & head.confident);
        end
    end
endmodule

// File: rtl/value_predict_unit.sv
// rtl/value_predict_unit.sv - last-value load predictor with checkpoint/rollback control
// Ports: clk, rst_n (async, active-low), bus (slave modport): req_* lookup request,
// pred_* prediction one cycle after acceptance, res_* in-order resolve of the oldest
// outstanding load, take_snapshot/recover/recover_pc/recovery_done checkpoint control,
// spec_active status, hit_count/miss_count saturating statistics.
module value_predict_unit
    import value_predict_unit_pkg::*;
#(
    parameter int DATA_WIDTH      = VP_DATA_WIDTH,
    parameter int ADDR_WIDTH      = VP_ADDR_WIDTH,
    parameter int TABLE_ENTRIES   = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CONF_BITS       = VP_CONF_BITS,
    parameter int CONF_THRESHOLD  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    value_predict_unit_if.slave  bus
);
    localparam int IDX_W = $clog2(TABLE_ENTRIES);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CONF_BITS-1:0] CONF_TH  = CONF_BITS'(CONF_THRESHOLD);
    localparam logic [CONF_BITS-1:0] CONF_MAX = '1;

    vp_state_t        state_q, state_d;
    vp_entry_t        table_q [TABLE_ENTRIES];
    vp_entry_t        look_e, train_e;
    vp_queue_t        q_head, q_push_data;
    logic             q_full, q_empty;
    logic [CNT_W-1:0] q_conf_count, conf_after;
    logic [IDX_W-1:0] req_idx, res_idx;
    logic [ADDR_WIDTH-1:0] req_tag, res_tag, ckpt_pc;
    logic             look_hit, look_conf;
    logic [DATA_WIDTH-1:0] look_value;
    logic             accept, res_fire, res_match;
    logic             req_ready, spec_active, snap_now, hit_now, miss_now;

    // Lookup uses the pre-update table entry even if the same index trains this cycle.
    assign req_idx    = bus.req_pc[IDX_W+1:2];
    assign req_tag    = bus.req_pc >> (IDX_W + 2);
    assign look_e     = table_q[req_idx];
    assign look_hit   = look_e.valid && (look_e.tag == req_tag);
    assign look_value = look_hit ? look_e.value : '0;
    assign look_conf  = look_hit && (look_e.conf >= CONF_TH);

    assign accept   = bus.req_valid & req_ready;
    assign res_fire = bus.res_valid & ~q_empty & (state_q != VP_RECOVER);
    assign res_idx  = q_head.pc[IDX_W+1:2];
    assign res_tag  = q_head.pc >> (IDX_W + 2);
    assign train_e  = table_q[res_idx];
    assign res_match = (bus.res_data == q_head.value);

    // Confident entries left once this cycle's push and pop have taken effect.
    assign conf_after = q_conf_count - CNT_W'(res_fire & q_head.confident)
                                     + CNT_W'(accept & look_conf);

    assign q_push_data = '{pc: bus.req_pc, value: look_value, confident: look_conf};

    vp_outstanding_queue #(.DEPTH(MAX_OUTSTANDING)) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (accept),
        .push_data  (q_push_data),
        .pop        (res_fire),
        .flush      (miss_now),
        .full       (q_full),
        .empty      (q_empty),
        .head       (q_head),
        .conf_count (q_conf_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TABLE_ENTRIES; i++) begin
                table_q[i] <= '0;
            end
        end else if (res_fire) begin
            if (train_e.valid && train_e.tag == res_tag && train_e.value == bus.res_data) begin
                if (train_e.conf != CONF_MAX) begin
                    table_q[res_idx].conf <= train_e.conf + 1'b1;
                end
            end else begin
                table_q[res_idx] <= '{valid: 1'b1, tag: res_tag, value: bus.res_data, conf: '0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= VP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            VP_IDLE:    if (snap_now) state_d = VP_SPEC;
            VP_SPEC:    if (miss_now) state_d = VP_RECOVER;
                        else if (conf_after == '0) state_d = VP_IDLE;
            VP_RECOVER: if (bus.recovery_done) state_d = VP_IDLE;
            default:    state_d = VP_IDLE;
        endcase
    end

    // req_ready is gated by rst_n so that every output reads 0 while reset is held.
    always_comb begin
        req_ready   = rst_n & ~q_full & (state_q != VP_RECOVER);
        spec_active = (state_q != VP_IDLE);
        snap_now    = (state_q == VP_IDLE) & accept & look_conf;
        hit_now     = (state_q == VP_SPEC) & res_fire & q_head.confident & res_match;
        miss_now    = (state_q == VP_SPEC) & res_fire & q_head.confident & ~res_match;
    end

    assign bus.req_ready   = req_ready;
    assign bus.spec_active = spec_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pred_valid     <= 1'b0;
            bus.pred_value     <= '0;
            bus.pred_confident <= 1'b0;
            bus.take_snapshot  <= 1'b0;
            bus.recover        <= 1'b0;
            bus.recover_pc     <= '0;
            bus.hit_count      <= '0;
            bus.miss_count     <= '0;
            ckpt_pc            <= '0;
        end else begin
            bus.pred_valid    <= accept;
            bus.take_snapshot <= snap_now;
            bus.recover       <= miss_now;
            if (accept) begin
                bus.pred_value     <= look_value;
                bus.pred_confident <= look_conf;
            end
            if (snap_now) begin
                ckpt_pc <= bus.req_pc;
            end
            if (miss_now) begin
                bus.recover_pc <= ckpt_pc;
            end
            if (hit_now && bus.hit_count != '1) begin
                bus.hit_count <= bus.hit_count + 1'b1;
            end
            if (miss_now && bus.miss_count != '1) begin
                bus.miss_count <= bus.miss_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_value_predict_unit.sv
// tb/tb_value_predict_unit.sv - self-checking bench for value_predict_unit
module tb_value_predict_unit;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    value_predict_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    value_predict_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          is_req;
        logic [31:0] arg;
        logic        pv;
        logic [31:0] val;
        logic        cf;
        logic        snap;
        logic        spec;
        logic [31:0] hit;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] PC_A  = 32'h0040_0010;
    localparam logic [31:0] PC_B  = 32'h0000_3004;
    localparam logic [31:0] PC_C  = 32'h0000_3008;
    localparam logic [31:0] PC_Q  = 32'h0000_0200;
    localparam logic [31:0] PC_L0 = 32'h0000_0100;
    localparam logic [31:0] PC_L1 = 32'h0000_1100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [31:0] pc);
        bus.req_valid = 1'b1;
        bus.req_pc    = pc;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic do_res(input logic [31:0] data);
        bus.res_valid = 1'b1;
        bus.res_data  = data;
        tick();
        bus.res_valid = 1'b0;
    endtask

    task automatic add(input bit r, input logic [31:0] a, input logic pv, input logic [31:0] v,
                       input logic cf, input logic sn, input logic sp, input logic [31:0] h);
        vecs.push_back('{is_req: r, arg: a, pv: pv, val: v, cf: cf, snap: sn, spec: sp, hit: h});
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 0);
        chk({tag, "_pred_valid"}, 32'(bus.pred_valid), 0);
        chk({tag, "_pred_value"}, bus.pred_value, 0);
        chk({tag, "_pred_conf"}, 32'(bus.pred_confident), 0);
        chk({tag, "_snapshot"}, 32'(bus.take_snapshot), 0);
        chk({tag, "_recover"}, 32'(bus.recover), 0);
        chk({tag, "_recover_pc"}, bus.recover_pc, 0);
        chk({tag, "_spec"}, 32'(bus.spec_active), 0);
        chk({tag, "_hit"}, bus.hit_count, 0);
        chk({tag, "_miss"}, bus.miss_count, 0);
    endtask

    initial begin
        int snaps;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.req_valid     = 1'b0;
        bus.req_pc        = '0;
        bus.res_valid     = 1'b0;
        bus.res_data      = '0;
        bus.recovery_done = 1'b0;

        // Train to confidence, then alias two PCs onto index 0.
        add(1, PC_A, 1, 32'h0, 0, 0, 0, 0);
        add(0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
        add(1, PC_A, 1, 32'hDEAD_BEEF, 0, 0, 0, 0);
        add(0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
        add(1, PC_A, 1, 32'hDEAD_BEEF, 0, 0, 0, 0);
        add(0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
        add(1, PC_A, 1, 32'hDEAD_BEEF, 1, 1, 1, 0);
        add(0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 1);
        add(1, PC_L0, 1, 32'h0, 0, 0, 0, 1);
        add(0, 32'hAAAA_0001, 0, 0, 0, 0, 0, 1);
        add(1, PC_L0, 1, 32'hAAAA_0001, 0, 0, 0, 1);
        add(0, 32'hAAAA_0001, 0, 0, 0, 0, 0, 1);
        add(1, PC_L1, 1, 32'h0, 0, 0, 0, 1);
        add(0, 32'hBBBB_0002, 0, 0, 0, 0, 0, 1);
        add(1, PC_L1, 1, 32'hBBBB_0002, 0, 0, 0, 1);
        add(0, 32'hBBBB_0002, 0, 0, 0, 0, 0, 1);
        add(1, PC_L0, 1, 32'h0, 0, 0, 0, 1);
        add(0, 32'hAAAA_0001, 0, 0, 0, 0, 0, 1);

        repeat (3) tick();
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("ready_after_reset", 32'(bus.req_ready), 1);

        foreach (vecs[i]) begin
            if (vecs[i].is_req) do_req(vecs[i].arg);
            else do_res(vecs[i].arg);
            chk($sformatf("vec%0d_pred_valid", i), 32'(bus.pred_valid), 32'(vecs[i].pv));
            if (vecs[i].pv) begin
                chk($sformatf("vec%0d_pred_value", i), bus.pred_value, vecs[i].val);
                chk($sformatf("vec%0d_pred_conf", i), 32'(bus.pred_confident), 32'(vecs[i].cf));
            end
            chk($sformatf("vec%0d_snapshot", i), 32'(bus.take_snapshot), 32'(vecs[i].snap));
            chk($sformatf("vec%0d_spec", i), 32'(bus.spec_active), 32'(vecs[i].spec));
            chk($sformatf("vec%0d_hit", i), bus.hit_count, vecs[i].hit);
        end

        // Mispredict from the trained state.
        do_req(PC_A);
        chk("mp_conf", 32'(bus.pred_confident), 1);
        chk("mp_snap", 32'(bus.take_snapshot), 1);
        do_res(32'h1234_5678);
        chk("mp_recover", 32'(bus.recover), 1);
        chk("mp_recover_pc", bus.recover_pc, PC_A);
        chk("mp_miss", bus.miss_count, 1);
        chk("mp_empty", 32'(dut.u_queue.empty), 1);
        chk("mp_ready", 32'(bus.req_ready), 0);
        tick();
        chk("mp_pulse_end", 32'(bus.recover), 0);
        chk("mp_pc_held", bus.recover_pc, PC_A);
        chk("mp_still_spec", 32'(bus.spec_active), 1);
        bus.recovery_done = 1'b1;
        tick();
        bus.recovery_done = 1'b0;
        chk("mp_idle", 32'(bus.spec_active), 0);
        chk("mp_ready_idle", 32'(bus.req_ready), 1);
        do_req(PC_A);
        chk("mp_new_value", bus.pred_value, 32'h1234_5678);
        chk("mp_new_conf", 32'(bus.pred_confident), 0);
        do_res(32'h1234_5678);

        // Queue full.
        for (int i = 0; i < 4; i++) begin
            do_req(PC_Q);
            chk($sformatf("full_ready%0d", i), 32'(bus.req_ready), (i == 3) ? 0 : 1);
        end
        do_res(32'h0000_0055);
        chk("full_ready_after_pop", 32'(bus.req_ready), 1);
        repeat (3) do_res(32'h0000_0055);
        chk("full_drained", 32'(dut.u_queue.empty), 1);

        // Two confident requests: one snapshot, rollback to the first PC.
        for (int i = 0; i < 3; i++) begin
            do_req(PC_B);
            do_res(32'h1111_1111);
            do_req(PC_C);
            do_res(32'h2222_2222);
        end
        snaps = 0;
        do_req(PC_B);
        snaps += int'(bus.take_snapshot);
        chk("ms_conf_b", 32'(bus.pred_confident), 1);
        do_req(PC_C);
        snaps += int'(bus.take_snapshot);
        chk("ms_conf_c", 32'(bus.pred_confident), 1);
        chk("ms_snap_count", snaps, 1);
        do_res(32'h1111_1111);
        chk("ms_hit", bus.hit_count, 2);
        chk("ms_spec", 32'(bus.spec_active), 1);
        do_res(32'h3333_3333);
        chk("ms_recover", 32'(bus.recover), 1);
        chk("ms_recover_pc", bus.recover_pc, PC_B);
        chk("ms_miss", bus.miss_count, 2);
        bus.recovery_done = 1'b1;
        tick();
        bus.recovery_done = 1'b0;
        chk("ms_idle", 32'(bus.spec_active), 0);

        // Asynchronous reset in SPEC with three entries queued.
        do_req(PC_B);
        do_req(PC_Q);
        do_req(PC_Q);
        chk("rst_pre_spec", 32'(bus.spec_active), 1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        chk("midrst_empty", 32'(dut.u_queue.empty), 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_req(PC_B);
        chk("post_rst_pv", 32'(bus.pred_valid), 1);
        chk("post_rst_value", bus.pred_value, 0);
        chk("post_rst_conf", 32'(bus.pred_confident), 0);
        do_res(32'h1111_1111);
        do_res(32'h9999_9999);
        chk("empty_res_hit", bus.hit_count, 0);
        chk("empty_res_miss", bus.miss_count, 0);
        chk("empty_res_empty", 32'(dut.u_queue.empty), 1);
        chk("empty_res_ready", 32'(bus.req_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
